// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing FSM with fetch/data hold, sticky halt and retire counter
module fetch_sequencer #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter int          RETIRE_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [31:0]         pc,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                dmem_req,
  input  logic                jump_valid,
  input  logic [31:0]         jump_target,
  input  logic                branch_taken,
  input  logic [31:0]         branch_offset,
  input  logic                halt_instr,
  output logic                pc_adv,
  output logic [31:0]         next_pc,
  output logic                imemREN,
  output logic [31:0]         imemaddr,
  output logic                dmem_en,
  output logic                halt,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [1:0] {FETCH, DATA, HALTED} state_t;
  state_t state;
  logic retire;
  logic [31:0] seq_pc;
  logic unused_pc_init;
  assign unused_pc_init = ^PC_INIT;
  assign imemaddr = pc;
  assign halt = state == HALTED;
  // Next-PC select and per-cycle enables; everything drops while reset is held
  always_comb begin
    seq_pc  = pc + 32'd4;
    next_pc = jump_valid ? jump_target : branch_taken ? seq_pc + branch_offset : seq_pc;
    imemREN = nRST && state == FETCH;
    dmem_en = nRST && state == DATA;
    pc_adv  = nRST && (state == FETCH ? ihit && !halt_instr && !dmem_req : state == DATA && dhit);
    retire  = state == FETCH ? ihit && (halt_instr || !dmem_req) : state == DATA && dhit;
  end
  // State transitions and retire counting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      if (state == FETCH && ihit) state <= halt_instr ? HALTED : dmem_req ? DATA : FETCH;
      else if (state == DATA && dhit) state <= FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
  logic CLK = 0, nRST = 0;
  logic [31:0] pc = 0, jump_target = 0, branch_offset = 0;
  logic ihit = 0, dhit = 0, dmem_req = 0, jump_valid = 0, branch_taken = 0, halt_instr = 0;
  logic pc_adv, imemREN, dmem_en, halt;
  logic [31:0] next_pc, imemaddr, retired;
  int passed = 0, total = 0;
  logic [31:0] exp_ret = 0;

  fetch_sequencer #(.PC_INIT(32'h0), .RETIRE_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .jump_valid(jump_valid), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .halt_instr(halt_instr), .pc_adv(pc_adv), .next_pc(next_pc),
    .imemREN(imemREN), .imemaddr(imemaddr), .dmem_en(dmem_en), .halt(halt), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic clear_in();
    ihit = 0; dhit = 0; dmem_req = 0; jump_valid = 0; branch_taken = 0; halt_instr = 0;
    jump_target = 0; branch_offset = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    clear_in(); ihit = 1; dhit = 1; nRST = 0; pc = 0;
    #3;
    total++; if (pc_adv !== 1'b0) $display("FAIL reset_pc_adv got %b want 0", pc_adv); else passed++;
    total++; if (imemREN !== 1'b0) $display("FAIL reset_imemREN got %b want 0", imemREN); else passed++;
    total++; if (dmem_en !== 1'b0) $display("FAIL reset_dmem_en got %b want 0", dmem_en); else passed++;
    total++; if (halt !== 1'b0) $display("FAIL reset_halt got %b want 0", halt); else passed++;
    total++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else passed++;
    clear_in(); tick(); nRST = 1; exp_ret = 0; #1;
    total++; if (imemREN !== 1'b1) $display("FAIL reset_release_imemREN got %b want 1", imemREN); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    clear_in(); pc = 0;
    for (int i = 0; i < 3; i++) begin
      ihit = 1; #1;
      want = 32'd4 * (i + 1);
      total++; if (pc_adv !== 1'b1) $display("FAIL seq_pc_adv[%0d] got %b want 1", i, pc_adv); else passed++;
      total++; if (next_pc !== want) $display("FAIL seq_next_pc[%0d] got %h want %h", i, next_pc, want); else passed++;
      total++; if (imemaddr !== pc) $display("FAIL seq_imemaddr[%0d] got %h want %h", i, imemaddr, pc); else passed++;
      tick(); pc = want; exp_ret++;
    end
    clear_in(); #1;
    total++; if (retired !== 32'd3) $display("FAIL seq_retired got %0d want 3", retired); else passed++;
  endtask

  task automatic test_data();
    clear_in(); pc = 32'h10; ihit = 1; dmem_req = 1; dhit = 1; #1;
    total++; if (pc_adv !== 1'b0) $display("FAIL data_issue_pc_adv got %b want 0", pc_adv); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      ihit = $urandom_range(0, 1); dhit = 0; #1;
      total++; if (imemREN !== 1'b0) $display("FAIL data_imemREN[%0d] got %b want 0", i, imemREN); else passed++;
      total++; if (dmem_en !== 1'b1) $display("FAIL data_dmem_en[%0d] got %b want 1", i, dmem_en); else passed++;
      total++; if (pc_adv !== 1'b0) $display("FAIL data_pc_adv[%0d] got %b want 0", i, pc_adv); else passed++;
      tick();
    end
    dhit = 1; #1;
    total++; if (pc_adv !== 1'b1) $display("FAIL data_dhit_pc_adv got %b want 1", pc_adv); else passed++;
    total++; if (next_pc !== 32'h14) $display("FAIL data_next_pc got %h want 00000014", next_pc); else passed++;
    tick(); exp_ret++; pc = 32'h14; clear_in(); #1;
    total++; if (retired !== exp_ret) $display("FAIL data_retired got %0d want %0d", retired, exp_ret); else passed++;
    total++; if (imemREN !== 1'b1) $display("FAIL data_back_fetch got %b want 1", imemREN); else passed++;
  endtask

  task automatic test_next_pc();
    clear_in(); pc = 32'h100; jump_valid = 1; jump_target = 32'h400; branch_taken = 1; branch_offset = 32'h20; #1;
    total++; if (next_pc !== 32'h400) $display("FAIL npc_jump_prio got %h want 00000400", next_pc); else passed++;
    jump_valid = 0; #1;
    total++; if (next_pc !== 32'h124) $display("FAIL npc_branch got %h want 00000124", next_pc); else passed++;
    branch_offset = 32'hFFFF_FFF0; #1;
    total++; if (next_pc !== 32'hF4) $display("FAIL npc_branch_neg got %h want 000000f4", next_pc); else passed++;
    clear_in(); pc = 32'hFFFF_FFFC; ihit = 1; #1;
    total++; if (next_pc !== 32'h0) $display("FAIL npc_wrap got %h want 00000000", next_pc); else passed++;
    total++; if (pc_adv !== 1'b1) $display("FAIL npc_wrap_adv got %b want 1", pc_adv); else passed++;
    tick(); exp_ret++; pc = 0; clear_in();
  endtask

  task automatic test_random();
    bit in_mem = 0;
    logic [31:0] want_npc;
    logic want_adv;
    for (int i = 0; i < 300; i++) begin
      if (!in_mem) begin
        dmem_req = ($urandom_range(0, 3) == 0); jump_valid = ($urandom_range(0, 3) == 0);
        branch_taken = $urandom_range(0, 1); jump_target = $urandom; branch_offset = $urandom;
      end
      ihit = $urandom_range(0, 1); dhit = $urandom_range(0, 1);
      want_npc = jump_valid ? jump_target : branch_taken ? pc + 4 + branch_offset : pc + 4;
      want_adv = in_mem ? dhit : ihit && !dmem_req;
      #1;
      total++; if (pc_adv !== want_adv) $display("FAIL rnd_pc_adv[%0d] got %b want %b", i, pc_adv, want_adv); else passed++;
      total++; if (next_pc !== want_npc) $display("FAIL rnd_next_pc[%0d] got %h want %h", i, next_pc, want_npc); else passed++;
      total++; if (imemREN !== !in_mem || dmem_en !== in_mem) $display("FAIL rnd_en[%0d] got %b%b want %b%b", i, imemREN, dmem_en, !in_mem, in_mem); else passed++;
      total++; if (retired !== exp_ret) $display("FAIL rnd_retired[%0d] got %0d want %0d", i, retired, exp_ret); else passed++;
      tick();
      if (in_mem && dhit) begin in_mem = 0; exp_ret++; end
      else if (!in_mem && ihit) begin if (dmem_req) in_mem = 1; else exp_ret++; end
      if (want_adv) pc = want_npc;
    end
    clear_in();
    while (in_mem) begin dhit = 1; tick(); in_mem = 0; exp_ret++; pc = pc + 4; end
    clear_in(); #1;
    total++; if (retired !== exp_ret) $display("FAIL rnd_final_retired got %0d want %0d", retired, exp_ret); else passed++;
  endtask

  task automatic test_reset_mid_data();
    clear_in(); ihit = 1; dmem_req = 1; tick();
    ihit = 0; dhit = 0; #1;
    total++; if (dmem_en !== 1'b1) $display("FAIL rst_data_enter got %b want 1", dmem_en); else passed++;
    dhit = 1; nRST = 0; #1;
    total++; if (dmem_en !== 1'b0) $display("FAIL rst_data_dmem_en got %b want 0", dmem_en); else passed++;
    total++; if (pc_adv !== 1'b0) $display("FAIL rst_data_pc_adv got %b want 0", pc_adv); else passed++;
    total++; if (retired !== 32'd0) $display("FAIL rst_data_retired got %0d want 0", retired); else passed++;
    clear_in(); tick(); nRST = 1; pc = 0; exp_ret = 0; #1;
    total++; if (imemREN !== 1'b1 || dmem_en !== 1'b0) $display("FAIL rst_data_fetch got %b%b want 10", imemREN, dmem_en); else passed++;
    total++; if (halt !== 1'b0) $display("FAIL rst_data_halt got %b want 0", halt); else passed++;
  endtask

  task automatic test_halt();
    clear_in(); pc = 32'h40; ihit = 1; halt_instr = 1; dmem_req = 1; jump_valid = 1; #1;
    total++; if (pc_adv !== 1'b0) $display("FAIL halt_issue_pc_adv got %b want 0", pc_adv); else passed++;
    total++; if (halt !== 1'b0) $display("FAIL halt_early got %b want 0", halt); else passed++;
    tick(); exp_ret++;
    for (int i = 0; i < 10; i++) begin
      ihit = 1; dhit = 1; dmem_req = $urandom_range(0, 1); halt_instr = $urandom_range(0, 1); #1;
      total++; if (halt !== 1'b1) $display("FAIL halt_sticky[%0d] got %b want 1", i, halt); else passed++;
      total++; if (pc_adv !== 1'b0 || imemREN !== 1'b0 || dmem_en !== 1'b0) $display("FAIL halt_outs[%0d] got %b%b%b want 000", i, pc_adv, imemREN, dmem_en); else passed++;
      tick();
    end
    total++; if (retired !== exp_ret) $display("FAIL halt_retired got %0d want %0d", retired, exp_ret); else passed++;
    clear_in(); nRST = 0; #1;
    total++; if (halt !== 1'b0) $display("FAIL halt_reset got %b want 0", halt); else passed++;
    tick(); nRST = 1; #1;
    total++; if (imemREN !== 1'b1) $display("FAIL halt_reset_fetch got %b want 1", imemREN); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_data();
    test_next_pc();
    test_random();
    test_reset_mid_data();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
